// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, sequencer states and the per-state control word.
package cpu_pkg;
  localparam int NUM_REGS = 16;
  localparam int OP_W     = 5;
  localparam int IR_W     = 32;

  localparam int OPC_HI = 31, OPC_LO = 27;
  localparam int RA_HI  = 26, RA_LO  = 23;
  localparam int RB_HI  = 22, RB_LO  = 19;
  localparam int RC_HI  = 18, RC_LO  = 15;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MULDIV, C_UNARY, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } cls_e;

  typedef struct packed {
    logic pc_in, pc_out, mar_in, mdr_in, mdr_out, mdr_read, inc_pc, ir_in, y_in;
    logic zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in, hi_out, lo_out, c_out;
    logic gra, grb, grc, rin, rout, illegal;
    logic [OP_W-1:0] op_code;
  } ctrl_t;

  function automatic cls_e op_class(input logic [OP_W-1:0] op);
    if (op >= OP_ADD && op <= OP_SHL)       return C_ALU;
    else if (op >= OP_ADDI && op <= OP_ORI) return C_IMM;
    else if (op == OP_MUL || op == OP_DIV)  return C_MULDIV;
    else if (op == OP_NEG || op == OP_NOT)  return C_UNARY;
    else if (op == OP_MFHI)                 return C_MFHI;
    else if (op == OP_MFLO)                 return C_MFLO;
    else if (op == OP_NOP)                  return C_NOP;
    else if (op == OP_HALT)                 return C_HALT;
    else                                    return C_ILL;
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [OP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/stop in, every datapath strobe out.
interface control_unit_if #(parameter int NUM_REGS = cpu_pkg::NUM_REGS);
  import cpu_pkg::*;
  logic [IR_W-1:0]     ir;
  logic                stop;
  logic [NUM_REGS-1:0] r_in, r_out;
  logic pc_in, pc_out, mar_in, mdr_in, mdr_out, mdr_read, inc_pc, ir_in, y_in;
  logic zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in, hi_out, lo_out, c_out;
  logic [OP_W-1:0]     op_code;
  logic                run, illegal;

  modport master (
    input  ir, stop,
    output r_in, r_out, pc_in, pc_out, mar_in, mdr_in, mdr_out, mdr_read, inc_pc,
           ir_in, y_in, zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in, hi_out,
           lo_out, c_out, op_code, run, illegal
  );
  modport slave (
    output ir, stop,
    input  r_in, r_out, pc_in, pc_out, mar_in, mdr_in, mdr_out, mdr_read, inc_pc,
           ir_in, y_in, zhi_in, zlo_in, zhi_out, zlo_out, hi_in, lo_in, hi_out,
           lo_out, c_out, op_code, run, illegal
  );
endinterface

// File: rtl/control_unit_select_encode.sv
// Register select/encode: picks Ra/Rb/Rc from the IR and decodes it one-hot
// onto the register write-enable and bus-drive lines.
module select_encode import cpu_pkg::*; #(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic [RA_HI:RC_LO]   ir,
  input  logic                 gra, grb, grc, rin, rout,
  output logic [NUM_REGS-1:0]  r_in,
  output logic [NUM_REGS-1:0]  r_out
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic [SEL_W-1:0]    sel;
  logic [NUM_REGS-1:0] onehot;

  always_comb begin
    sel = '0;
    if (gra)      sel = ir[RA_HI:RA_LO];
    else if (grb) sel = ir[RB_HI:RB_LO];
    else if (grc) sel = ir[RC_HI:RC_LO];
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
    assign onehot[i] = (sel == SEL_W'(i));
  end

  assign r_in  = rin  ? onehot : '0;
  assign r_out = rout ? onehot : '0;
endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, decode in T3, per-class execute
// through T6. Outputs depend only on the state register and ir.
module control_unit import cpu_pkg::*; #(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic             clk,
  input  logic             reset_n,
  control_unit_if.master   cu
);
  state_e          state_q, state_d;
  ctrl_t           ctrl;
  logic [OP_W-1:0] opc;
  cls_e            cls;

  assign opc = cu.ir[OPC_HI:OPC_LO];
  assign cls = op_class(opc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.zlo_in = 1'b1;
        state_d = cu.stop ? S_HALT : S_T1;
      end
      S_T1: begin
        ctrl.zlo_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.mdr_read = 1'b1; ctrl.mdr_in = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T0;
        case (cls)
          C_ALU, C_IMM: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; state_d = S_T4; end
          C_MULDIV:     begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; state_d = S_T4; end
          C_UNARY: begin
            ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zlo_in = 1'b1; ctrl.op_code = opc;
            state_d = S_T4;
          end
          C_MFHI:  begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_MFLO:  begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_HALT:  state_d = S_HALT;
          C_ILL:   ctrl.illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (cls)
          C_ALU: begin ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.zlo_in = 1'b1; ctrl.op_code = opc; end
          C_IMM: begin ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1; ctrl.op_code = imm_alu_op(opc); end
          C_MULDIV: begin
            ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.zlo_in = 1'b1; ctrl.zhi_in = 1'b1;
            ctrl.op_code = opc;
          end
          C_UNARY: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; state_d = S_T0; end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T0;
        case (cls)
          C_ALU, C_IMM: begin ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          C_MULDIV:     begin ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1; state_d = S_T6; end
          default: ;
        endcase
      end
      S_T6: begin
        ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1;
        state_d = S_T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  select_encode #(.NUM_REGS(NUM_REGS)) u_sel (
    .ir    (cu.ir[RA_HI:RC_LO]),
    .gra   (ctrl.gra),
    .grb   (ctrl.grb),
    .grc   (ctrl.grc),
    .rin   (ctrl.rin),
    .rout  (ctrl.rout),
    .r_in  (cu.r_in),
    .r_out (cu.r_out)
  );

  assign cu.pc_in    = ctrl.pc_in;
  assign cu.pc_out   = ctrl.pc_out;
  assign cu.mar_in   = ctrl.mar_in;
  assign cu.mdr_in   = ctrl.mdr_in;
  assign cu.mdr_out  = ctrl.mdr_out;
  assign cu.mdr_read = ctrl.mdr_read;
  assign cu.inc_pc   = ctrl.inc_pc;
  assign cu.ir_in    = ctrl.ir_in;
  assign cu.y_in     = ctrl.y_in;
  assign cu.zhi_in   = ctrl.zhi_in;
  assign cu.zlo_in   = ctrl.zlo_in;
  assign cu.zhi_out  = ctrl.zhi_out;
  assign cu.zlo_out  = ctrl.zlo_out;
  assign cu.hi_in    = ctrl.hi_in;
  assign cu.lo_in    = ctrl.lo_in;
  assign cu.hi_out   = ctrl.hi_out;
  assign cu.lo_out   = ctrl.lo_out;
  assign cu.c_out    = ctrl.c_out;
  assign cu.op_code  = ctrl.op_code;
  assign cu.illegal  = ctrl.illegal;
  assign cu.run      = (state_q != S_RESET) && (state_q != S_HALT);
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by
// cycle and compares the full output word against hand-derived values.
module tb_control_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  control_unit_if #(.NUM_REGS(16)) cu();
  control_unit #(.NUM_REGS(16)) dut (.clk(clk), .reset_n(reset_n), .cu(cu.master));

  int tests = 0;
  int fails = 0;

  // Strobe masks, MSB first in the same order as strb().
  localparam logic [17:0] M_PC_IN   = 18'h20000, M_PC_OUT  = 18'h10000, M_MAR_IN  = 18'h08000;
  localparam logic [17:0] M_MDR_IN  = 18'h04000, M_MDR_OUT = 18'h02000, M_MDR_RD  = 18'h01000;
  localparam logic [17:0] M_INC_PC  = 18'h00800, M_IR_IN   = 18'h00400, M_Y_IN    = 18'h00200;
  localparam logic [17:0] M_ZHI_IN  = 18'h00100, M_ZLO_IN  = 18'h00080, M_ZHI_OUT = 18'h00040;
  localparam logic [17:0] M_ZLO_OUT = 18'h00020, M_HI_IN   = 18'h00010, M_LO_IN   = 18'h00008;
  localparam logic [17:0] M_HI_OUT  = 18'h00004, M_LO_OUT  = 18'h00002, M_C_OUT   = 18'h00001;

  localparam logic [17:0] S_FETCH0 = M_PC_OUT | M_MAR_IN | M_INC_PC | M_ZLO_IN;
  localparam logic [17:0] S_FETCH1 = M_ZLO_OUT | M_PC_IN | M_MDR_RD | M_MDR_IN;
  localparam logic [17:0] S_FETCH2 = M_MDR_OUT | M_IR_IN;

  function automatic logic [17:0] strb();
    return {cu.pc_in, cu.pc_out, cu.mar_in, cu.mdr_in, cu.mdr_out, cu.mdr_read, cu.inc_pc,
            cu.ir_in, cu.y_in, cu.zhi_in, cu.zlo_in, cu.zhi_out, cu.zlo_out, cu.hi_in,
            cu.lo_in, cu.hi_out, cu.lo_out, cu.c_out};
  endfunction

  function automatic logic [56:0] obs();
    return {strb(), cu.r_in, cu.r_out, cu.op_code, cu.run, cu.illegal};
  endfunction

  function automatic logic [56:0] ex(input logic [17:0] s, input logic [15:0] ri, ro,
                                     input logic [4:0] op, input logic rn, il);
    return {s, ri, ro, op, rn, il};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra, rb, rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at the negedge inside T0; leaves the bench inside T3 with ir loaded.
  task automatic do_fetch(input string nm, input logic [31:0] instr);
    logic [56:0] e;
    e = ex(S_FETCH0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL %s_t0 got %h exp %h", nm, obs(), e); end
    tick();
    e = ex(S_FETCH1, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL %s_t1 got %h exp %h", nm, obs(), e); end
    tick();
    e = ex(S_FETCH2, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL %s_t2 got %h exp %h", nm, obs(), e); end
    cu.ir = instr;
    tick();
  endtask

  task automatic test_reset();
    logic [56:0] e;
    reset_n = 1'b0;
    repeat (2) tick();
    e = '0; tests++;
    if (obs() !== e) begin fails++; $display("FAIL reset_hold got %h exp %h", obs(), e); end
    reset_n = 1'b1;
    tick();
    e = ex(S_FETCH0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL reset_to_t0 got %h exp %h", obs(), e); end
  endtask

  // Generic 3-operand ALU walk: T3 drives Rb, T4 drives Rc (or c_out), T5 writes Ra.
  task automatic test_and();
    logic [56:0] e;
    do_fetch("and", 32'h28918000);
    e = ex(M_Y_IN, 0, 16'h0004, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL and_t3 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_IN, 0, 16'h0008, 5'b00101, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL and_t4 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_OUT, 16'h0002, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL and_t5 got %h exp %h", obs(), e); end
    tick();
  endtask

  // 62A7FFFD: opcode 01100, ir[26:23]=5 (Ra), ir[22:19]=4 (Rb), imm=-3.
  task automatic test_addi();
    logic [56:0] e;
    do_fetch("addi", 32'h62A7FFFD);
    e = ex(M_Y_IN, 0, 16'h0010, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL addi_t3 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_IN | M_C_OUT, 0, 0, 5'b00011, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL addi_t4 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_OUT, 16'h0020, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL addi_t5 got %h exp %h", obs(), e); end
    tick();
  endtask

  task automatic test_same_reg();
    logic [56:0] e;
    do_fetch("andsame", mk(5'b00101, 4'd1, 4'd1, 4'd1));
    e = ex(M_Y_IN, 0, 16'h0002, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL same_t3 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_IN, 0, 16'h0002, 5'b00101, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL same_t4 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_OUT, 16'h0002, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL same_t5 got %h exp %h", obs(), e); end
    tick();
  endtask

  task automatic test_mul();
    logic [56:0] e;
    do_fetch("mul", 32'h7B380000);
    e = ex(M_Y_IN, 0, 16'h0040, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL mul_t3 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_IN | M_ZHI_IN, 0, 16'h0080, 5'b01111, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL mul_t4 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_OUT | M_LO_IN, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL mul_t5 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZHI_OUT | M_HI_IN, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL mul_t6 got %h exp %h", obs(), e); end
    tick();
    e = ex(S_FETCH0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL mul_back_t0 got %h exp %h", obs(), e); end
  endtask

  task automatic test_unary_misc();
    logic [56:0] e;
    do_fetch("neg", mk(5'b10001, 4'd2, 4'd3, 4'd0));
    e = ex(M_ZLO_IN, 0, 16'h0008, 5'b10001, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL neg_t3 got %h exp %h", obs(), e); end
    tick();
    e = ex(M_ZLO_OUT, 16'h0004, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL neg_t4 got %h exp %h", obs(), e); end
    tick();
    do_fetch("mflo", mk(5'b11001, 4'd9, 4'd0, 4'd0));
    e = ex(M_LO_OUT, 16'h0200, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL mflo_t3 got %h exp %h", obs(), e); end
    tick();
    do_fetch("mfhi", mk(5'b11000, 4'd15, 4'd0, 4'd0));
    e = ex(M_HI_OUT, 16'h8000, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL mfhi_t3 got %h exp %h", obs(), e); end
    tick();
    do_fetch("nop", mk(5'b11010, 4'd3, 4'd4, 4'd5));
    e = ex(0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL nop_t3 got %h exp %h", obs(), e); end
    tick();
    do_fetch("ill_ld", mk(5'b00000, 4'd1, 4'd2, 4'd3));
    e = ex(0, 0, 0, 0, 1, 1); tests++;
    if (obs() !== e) begin fails++; $display("FAIL ill_ld_t3 got %h exp %h", obs(), e); end
    tick();
    do_fetch("ill_hi", mk(5'b11111, 4'd1, 4'd2, 4'd3));
    e = ex(0, 0, 0, 0, 1, 1); tests++;
    if (obs() !== e) begin fails++; $display("FAIL ill_hi_t3 got %h exp %h", obs(), e); end
    tick();
  endtask

  task automatic test_halt();
    logic [56:0] e;
    do_fetch("halt", mk(5'b11011, 4'd0, 4'd0, 4'd0));
    e = ex(0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL halt_t3 got %h exp %h", obs(), e); end
    for (int i = 0; i < 10; i++) begin
      tick();
      e = '0; tests++;
      if (obs() !== e) begin fails++; $display("FAIL halt_hold%0d got %h exp %h", i, obs(), e); end
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    e = ex(S_FETCH0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL halt_restart got %h exp %h", obs(), e); end
  endtask

  task automatic test_stop();
    logic [56:0] e;
    cu.stop = 1'b1;
    #1;
    e = ex(S_FETCH0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL stop_t0 got %h exp %h", obs(), e); end
    tick();
    e = '0; tests++;
    if (obs() !== e) begin fails++; $display("FAIL stop_halt got %h exp %h", obs(), e); end
    cu.stop = 1'b0;
    tick();
    e = '0; tests++;
    if (obs() !== e) begin fails++; $display("FAIL stop_halt_hold got %h exp %h", obs(), e); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [56:0] e;
    do_fetch("rstmid", 32'h28918000);
    tick();
    e = ex(M_ZLO_IN, 0, 16'h0008, 5'b00101, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL rstmid_t4 got %h exp %h", obs(), e); end
    #1 reset_n = 1'b0;
    #1;
    e = '0; tests++;
    if (obs() !== e) begin fails++; $display("FAIL rstmid_async got %h exp %h", obs(), e); end
    tick();
    e = '0; tests++;
    if (obs() !== e) begin fails++; $display("FAIL rstmid_hold got %h exp %h", obs(), e); end
    reset_n = 1'b1;
    tick();
    e = ex(S_FETCH0, 0, 0, 0, 1, 0); tests++;
    if (obs() !== e) begin fails++; $display("FAIL rstmid_t0 got %h exp %h", obs(), e); end
  endtask

  // R1 must never see a write enable while the reset-interrupted "and" is in flight.
  logic r1_written = 1'b0;
  logic watch_r1 = 1'b0;
  always @(posedge clk) if (watch_r1 && cu.r_in[1]) r1_written <= 1'b1;

  initial begin
    cu.ir   = '0;
    cu.stop = 1'b0;
    test_reset();
    test_and();
    test_addi();
    test_same_reg();
    test_mul();
    test_unary_misc();
    test_halt();
    test_stop();
    watch_r1 = 1'b1;
    test_reset_mid();
    repeat (4) tick();
    watch_r1 = 1'b0;
    tests++;
    if (r1_written !== 1'b0) begin fails++; $display("FAIL rstmid_r1 got %b exp 0", r1_written); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
